// File: rtl/wb_arbiter_pkg.sv
// Shared widths, register-file constants and arbitration types for the
// writeback arbiter and its scoreboard.
package wb_arbiter_pkg;

  localparam int REG_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic {
    GRANT_LSU = 1'b0,
    GRANT_DIV = 1'b1
  } grant_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [REG_W-1:0]  wdata;
  } wr_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy-bit scoreboard for long-latency destinations; flags ID source hazards,
// treating a register written by this cycle's long grant as already available.
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_valid,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              hazard
);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic                hit1;
  logic                hit2;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bits
      // x0 is hard-wired, so it can never become busy.
      assign set_vec[gi] = (gi != 0) && set_valid && (set_addr == ADDR_W'(gi));
      assign clr_vec[gi] = clr_valid && (clr_addr == ADDR_W'(gi));
    end
  endgenerate

  // Set is applied after clear so a same-cycle issue to the same register wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= (busy_reg & ~clr_vec) | set_vec;
    end
  end

  always_comb begin
    hit1   = busy_reg[raddr1] && !(clr_valid && (clr_addr == raddr1));
    hit2   = busy_reg[raddr2] && !(clr_valid && (clr_addr == raddr2));
    hazard = hit1 || hit2;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Single-port register-file writeback arbiter: EX has priority, LSU and DIV
// share the remaining slots round-robin, and an aging counter holds EX off.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic [REG_W-1:0]  ex_wdata_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [ADDR_W-1:0] lsu_waddr_i,
  input  logic [REG_W-1:0]  lsu_wdata_i,
  input  logic              div_valid_i,
  output logic              div_ready_o,
  input  logic [ADDR_W-1:0] div_waddr_i,
  input  logic [REG_W-1:0]  div_wdata_i,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_rd_i,
  input  logic [ADDR_W-1:0] id_raddr1_i,
  input  logic [ADDR_W-1:0] id_raddr2_i,
  output logic              id_hazard_o,
  output logic              ex_hold_o,
  output logic              reg_we_o,
  output logic [ADDR_W-1:0] reg_waddr_o,
  output logic [REG_W-1:0]  reg_wdata_o
);

  localparam int AGE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] age_reg;
  logic [AGE_W-1:0] age_next;
  logic             ex_hold_reg;
  logic             ex_hold_next;
  grant_e           last_grant_reg;

  logic    ex_active;
  logic    pick_lsu;
  logic    lsu_grant;
  logic    div_grant;
  logic    long_grant;
  wr_req_t wr_sel;

  always_comb begin
    ex_active = ex_we_i && !ex_hold_reg;
    // On a tie the requester not served last wins; reset leaves DIV as last.
    pick_lsu   = lsu_valid_i && (!div_valid_i || (last_grant_reg == GRANT_DIV));
    lsu_grant  = !rst && !ex_active && pick_lsu;
    div_grant  = !rst && !ex_active && div_valid_i && !pick_lsu;
    long_grant = lsu_grant || div_grant;

    wr_sel = '0;
    if (!rst && ex_active) begin
      wr_sel = '{we: WRITE_ENABLE, waddr: ex_waddr_i, wdata: ex_wdata_i};
    end else if (lsu_grant) begin
      wr_sel = '{we: WRITE_ENABLE, waddr: lsu_waddr_i, wdata: lsu_wdata_i};
    end else if (div_grant) begin
      wr_sel = '{we: WRITE_ENABLE, waddr: div_waddr_i, wdata: div_wdata_i};
    end

    // Writes to x0 still complete the handshake but never reach the file.
    reg_we_o    = wr_sel.we && (wr_sel.waddr != ZERO_REG);
    reg_waddr_o = reg_we_o ? wr_sel.waddr : '0;
    reg_wdata_o = reg_we_o ? wr_sel.wdata : '0;
    lsu_ready_o = lsu_grant;
    div_ready_o = div_grant;
  end

  // A hold cycle always consumes the starvation event, so hold lasts one cycle.
  always_comb begin
    age_next = age_reg;
    if (long_grant || ex_hold_reg) begin
      age_next = '0;
    end else if ((lsu_valid_i || div_valid_i) && (age_reg != AGE_MAX)) begin
      age_next = age_reg + AGE_W'(1);
    end
    ex_hold_next = (age_next == AGE_MAX) && !ex_hold_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_reg        <= '0;
      ex_hold_reg    <= 1'b0;
      last_grant_reg <= GRANT_DIV;
    end else begin
      age_reg     <= age_next;
      ex_hold_reg <= ex_hold_next;
      if (lsu_grant) begin
        last_grant_reg <= GRANT_LSU;
      end else if (div_grant) begin
        last_grant_reg <= GRANT_DIV;
      end
    end
  end

  assign ex_hold_o = ex_hold_reg;

  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (iss_valid_i),
    .set_addr  (iss_rd_i),
    .clr_valid (long_grant),
    .clr_addr  (lsu_grant ? lsu_waddr_i : div_waddr_i),
    .raddr1    (id_raddr1_i),
    .raddr2    (id_raddr2_i),
    .hazard    (id_hazard_o)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for single-cycle behaviour plus
// hand sequences for starvation, mid-handshake reset and post-reset round-robin.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        ex_we_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic        div_valid_i;
  logic        div_ready_o;
  logic [4:0]  div_waddr_i;
  logic [31:0] div_wdata_i;
  logic        iss_valid_i;
  logic [4:0]  iss_rd_i;
  logic [4:0]  id_raddr1_i;
  logic [4:0]  id_raddr2_i;
  logic        id_hazard_o;
  logic        ex_hold_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  int n_cmp;
  int n_fail;

  wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_we_i     (ex_we_i),
    .ex_waddr_i  (ex_waddr_i),
    .ex_wdata_i  (ex_wdata_i),
    .lsu_valid_i (lsu_valid_i),
    .lsu_ready_o (lsu_ready_o),
    .lsu_waddr_i (lsu_waddr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .div_valid_i (div_valid_i),
    .div_ready_o (div_ready_o),
    .div_waddr_i (div_waddr_i),
    .div_wdata_i (div_wdata_i),
    .iss_valid_i (iss_valid_i),
    .iss_rd_i    (iss_rd_i),
    .id_raddr1_i (id_raddr1_i),
    .id_raddr2_i (id_raddr2_i),
    .id_hazard_o (id_hazard_o),
    .ex_hold_o   (ex_hold_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_wdata_o (reg_wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ex_we;
    logic [4:0]  ex_a;
    logic [31:0] ex_d;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        dv;
    logic [4:0]  da;
    logic [31:0] dd;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_lr;
    logic        e_dr;
    logic        e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    logic        e_hold;
    logic        e_haz;
    logic        chk_d;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl[NVEC];

  function automatic vec_t mk(input int ex_we, input int ex_a, input logic [31:0] ex_d,
                              input int lv, input int la, input logic [31:0] ld,
                              input int dv, input int da, input logic [31:0] dd,
                              input int iv, input int ird, input int r1, input int r2,
                              input int e_lr, input int e_dr, input int e_we, input int e_a,
                              input logic [31:0] e_d, input int e_hold, input int e_haz,
                              input int chk_d);
    vec_t v;
    v.ex_we = 1'(ex_we); v.ex_a = 5'(ex_a); v.ex_d = ex_d;
    v.lv = 1'(lv); v.la = 5'(la); v.ld = ld;
    v.dv = 1'(dv); v.da = 5'(da); v.dd = dd;
    v.iv = 1'(iv); v.ird = 5'(ird); v.r1 = 5'(r1); v.r2 = 5'(r2);
    v.e_lr = 1'(e_lr); v.e_dr = 1'(e_dr); v.e_we = 1'(e_we); v.e_a = 5'(e_a);
    v.e_d = e_d; v.e_hold = 1'(e_hold); v.e_haz = 1'(e_haz); v.chk_d = 1'(chk_d);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ex_we_i = v.ex_we; ex_waddr_i = v.ex_a; ex_wdata_i = v.ex_d;
    lsu_valid_i = v.lv; lsu_waddr_i = v.la; lsu_wdata_i = v.ld;
    div_valid_i = v.dv; div_waddr_i = v.da; div_wdata_i = v.dd;
    iss_valid_i = v.iv; iss_rd_i = v.ird;
    id_raddr1_i = v.r1; id_raddr2_i = v.r2;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic cmp(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, required 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic e_lr, input logic e_dr,
                           input logic e_we, input logic [4:0] e_a, input logic [31:0] e_d,
                           input logic e_hold, input logic e_haz, input logic chk_d);
    cmp({tag, ".lsu_ready"}, idx, 32'(lsu_ready_o), 32'(e_lr));
    cmp({tag, ".div_ready"}, idx, 32'(div_ready_o), 32'(e_dr));
    cmp({tag, ".reg_we"}, idx, 32'(reg_we_o), 32'(e_we));
    cmp({tag, ".reg_waddr"}, idx, 32'(reg_waddr_o), 32'(e_a));
    if (chk_d) cmp({tag, ".reg_wdata"}, idx, reg_wdata_o, e_d);
    cmp({tag, ".ex_hold"}, idx, 32'(ex_hold_o), 32'(e_hold));
    cmp({tag, ".id_hazard"}, idx, 32'(id_hazard_o), 32'(e_haz));
    $display("%s %0d: lsu_ready=%0b div_ready=%0b we=%0b waddr=%0d wdata=0x%0h hold=%0b hazard=%0b",
             tag, idx, lsu_ready_o, div_ready_o, reg_we_o, reg_waddr_o, reg_wdata_o,
             ex_hold_o, id_hazard_o);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    // ex_we ex_a ex_d | lv la ld | dv da dd | iv ird r1 r2 || lr dr we a d hold haz chk
    tbl[0]  = mk(1, 5, 32'h1234,  1, 6, 32'hAAAA0006, 0, 0, 0,       0, 0, 0, 0,  0, 0, 1, 5, 32'h1234, 0, 0, 1);
    tbl[1]  = mk(0, 0, 0,         1, 6, 32'hAAAA0006, 0, 0, 0,       0, 0, 0, 0,  1, 0, 1, 6, 32'hAAAA0006, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0,         1, 8, 32'h08,       1, 9, 32'h09,  0, 0, 0, 0,  0, 1, 1, 9, 32'h09, 0, 0, 1);
    tbl[3]  = mk(0, 0, 0,         1, 8, 32'h08,       1, 10, 32'h0A, 0, 0, 0, 0,  1, 0, 1, 8, 32'h08, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0,         1, 11, 32'h0B,      1, 10, 32'h0A, 0, 0, 0, 0,  0, 1, 1, 10, 32'h0A, 0, 0, 1);
    tbl[5]  = mk(0, 0, 0,         0, 0, 0,            0, 0, 0,       1, 7, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(0, 0, 0,         0, 0, 0,            0, 0, 0,       0, 0, 7, 0,  0, 0, 0, 0, 0, 0, 1, 1);
    tbl[7]  = mk(1, 3, 32'h33,    0, 0, 0,            0, 0, 0,       0, 0, 3, 7,  0, 0, 1, 3, 32'h33, 0, 1, 1);
    tbl[8]  = mk(0, 0, 0,         1, 7, 32'h77,       0, 0, 0,       0, 0, 7, 0,  1, 0, 1, 7, 32'h77, 0, 0, 1);
    tbl[9]  = mk(0, 0, 0,         0, 0, 0,            0, 0, 0,       0, 0, 7, 0,  0, 0, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk(0, 0, 0,         1, 12, 32'h0C,      0, 0, 0,       1, 12, 0, 0, 1, 0, 1, 12, 32'h0C, 0, 0, 1);
    tbl[11] = mk(0, 0, 0,         0, 0, 0,            0, 0, 0,       1, 0, 12, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[12] = mk(0, 0, 0,         0, 0, 0,            0, 0, 0,       0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 0,         0, 0, 0,            1, 12, 32'hCC, 0, 0, 0, 12, 0, 1, 1, 12, 32'hCC, 0, 0, 1);
    tbl[14] = mk(0, 0, 0,         1, 0, 32'hDEAD,     0, 0, 0,       0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 32'h55,    0, 0, 0,            1, 13, 32'h0D, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0,         0, 0, 0,            1, 13, 32'h0D, 0, 0, 0, 0,  0, 1, 1, 13, 32'h0D, 0, 0, 1);

    // Outputs stay quiet while reset is held even with live requests.
    rst = 1'b1;
    drive(mk(1, 4, 32'h44, 1, 6, 32'h66, 1, 7, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      @(negedge clk);
      check_all("vec", i, tbl[i].e_lr, tbl[i].e_dr, tbl[i].e_we, tbl[i].e_a, tbl[i].e_d,
                tbl[i].e_hold, tbl[i].e_haz, tbl[i].chk_d);
    end

    // Starvation: EX writes every cycle while DIV waits; hold in cycles 5 and 10.
    for (int c = 1; c <= 10; c++) begin
      logic h;
      h = (c == 5) || (c == 10);
      @(posedge clk); #1;
      drive(mk(1, 20, 32'h2020, 0, 0, 0, 1, 21, 32'h2121, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      check_all("starve", c, 0, h, 1, h ? 5'd21 : 5'd20, h ? 32'h2121 : 32'h2020, h, 0, 1);
    end

    // Build state (busy x9, aging 3) and reset in the middle of a pending transfer.
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check_all("pre_rst", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      drive(mk(1, 20, 32'h2020, 0, 0, 0, 1, 21, 32'h2121, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      check_all("pre_rst", c, 0, 0, 1, 20, 32'h2020, 0, 1, 1);
    end
    @(posedge clk); #1;
    drive(mk(1, 20, 32'h2020, 1, 3, 32'h33, 1, 21, 32'h2121, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    check_all("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    @(negedge clk);
    rst = 1'b0;

    // First tie after reset goes to LSU, then alternates; busy x9 is gone.
    for (int c = 0; c < 3; c++) begin
      logic l;
      l = (c != 1);
      @(posedge clk); #1;
      drive(mk(0, 0, 0, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      check_all("rr", c, l, !l, 1, l ? 5'd1 : 5'd2, l ? 32'h11 : 32'h22, 0, 0, 1);
    end

    // Aging restarted from 0: hold only in the 5th blocked cycle.
    for (int c = 1; c <= 5; c++) begin
      logic h;
      h = (c == 5);
      @(posedge clk); #1;
      drive(mk(1, 20, 32'h2020, 0, 0, 0, 1, 21, 32'h2121, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      check_all("age_rst", c, 0, h, 1, h ? 5'd21 : 5'd20, h ? 32'h2121 : 32'h2020, h, 0, 1);
    end

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive cycles a long-latency writeback may wait before EX is held.
REQ-002 The block SHALL use one clock, clk; reset is rst, asynchronous and active-high.
REQ-003 Ports, listed as name  direction  width  meaning:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ex_we_i  in  1  EX write request
- ex_waddr_i  in  5  EX write address
- ex_wdata_i  in  32  EX write data
- lsu_valid_i  in  1  load-return request
- lsu_ready_o  out  1  load-return grant
- lsu_waddr_i  in  5  load-return write address
- lsu_wdata_i  in  32  load-return write data
- div_valid_i  in  1  divider-result request
- div_ready_o  out  1  divider-result grant
- div_waddr_i  in  5  divider-result write address
- div_wdata_i  in  32  divider-result write data
- iss_valid_i  in  1  long-latency op (load/div) issued this cycle
- iss_rd_i  in  5  destination of that op
- id_raddr1_i  in  5  ID source address 1
- id_raddr2_i  in  5  ID source address 2
- id_hazard_o  out  1  ID must stall (source pending)
- ex_hold_o  out  1  EX must hold its result and not write
- reg_we_o  out  1  register file write enable
- reg_waddr_o  out  5  register file write address
- reg_wdata_o  out  32  register file write data

Function
REQ-004 Single register-file write port; the grant and reg_* outputs SHALL be combinational in the same cycle (zero latency).
REQ-005 When ex_hold_o=0, EX SHALL have absolute priority: if ex_we_i=1, EX drives reg_*, and lsu_ready_o=div_ready_o=0.
REQ-006 When ex_hold_o=1, EX SHALL be ignored; EX asserts no write that cycle.
REQ-007 When the port is free, arbitration between LSU and DIV SHALL be round-robin. A one-bit last-grant flop picks the requester not granted last when both are valid; a single valid requester is granted.
REQ-008 Handshake: a transfer occurs when valid and ready are both 1. The requester SHALL hold waddr/wdata stable while valid && !ready. The block SHALL NOT assert ready without valid.
REQ-009 A granted write with address 0 SHALL complete the handshake with reg_we_o=0.
REQ-010 With no grant: reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0.
REQ-011 Aging counter (0..STARVE_LIMIT):
- increments each cycle lsu_valid_i or div_valid_i is 1 and neither is granted;
- clears on any LSU/DIV grant;
- when it equals STARVE_LIMIT, ex_hold_o=1 (registered), forcing the next cycle to grant a long requester.
REQ-012 ex_hold_o SHALL be high for exactly one cycle per starvation event.
REQ-013 Scoreboard: 32 busy bits; bit 0 is never set.
- iss_valid_i sets busy[iss_rd_i].
- A granted LSU/DIV write clears busy[waddr].
- Set and clear of the same register in the same cycle: set wins.
REQ-014 id_hazard_o SHALL be 1 if busy[id_raddr1_i] or busy[id_raddr2_i] (non-zero addresses), excluding a register being written this cycle by a long grant; the register file bypasses same-cycle writes.
REQ-015 EX writes SHALL NOT modify the scoreboard; WAW avoidance is ID's responsibility via id_hazard_o.

Reset
REQ-016 On rst:
- busy bits, aging counter and ex_hold_o clear to 0 immediately (asynchronous);
- last-grant = DIV, so LSU wins the first tie.
REQ-017 While rst is high, all outputs SHALL be 0. Reset mid-handshake drops the pending transfer; requesters are reset together.

Structure
REQ-018 Register width, address width, ZeroReg, WriteEnable and STARVE_LIMIT default SHALL live in the shared defines include.
REQ-019 The busy-bit array, set/clear logic and hazard lookup SHALL be a sub-module wb_scoreboard; arbitration and aging remain in wb_arbiter.

Verification
REQ-020 ex_we_i=1 to x5=0x1234, lsu_valid_i=1 to x6 in the same cycle -> reg_waddr_o=5, data 0x1234, lsu_ready_o=0; next cycle (ex idle) -> x6 written, lsu_ready_o=1.
REQ-021 lsu and div both valid for 3 free cycles, single-beat each, reissued -> grants LSU, DIV, LSU.
REQ-022 ex_we_i=1 continuously, div_valid_i=1, STARVE_LIMIT=4 -> ex_hold_o=1 in the 5th cycle, div granted that cycle, counter back to 0.
REQ-023 iss_valid_i with rd=7, then id_raddr1_i=7 -> id_hazard_o=1 until the LSU write to x7 is granted; 0 in the grant cycle; rd=0 issue never hazards.
REQ-024 LSU write to x0 granted -> lsu_ready_o=1, reg_we_o=0; assert rst while div valid and aging=3 -> all outputs 0, busy cleared, first tie after release goes to LSU.
